// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - FIFO-buffered command sequencer for a 4-bit combinational ALU
// Optional completed-operation counter (op_count) enabled by `define ALU_SEQ_STATS_EN
module alu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_opcode,
  input  logic [3:0]        cmd_a,
  input  logic [3:0]        cmd_b,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic [3:0]        alu_opcode,
  input  logic [3:0]        alu_x,
  input  logic [3:0]        alu_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_x,
  output logic [3:0]        res_y,
  output logic [3:0]        res_opcode,
  output logic              busy
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [STAT_W-1:0] op_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RESULT} state_t;

  state_t        r_state;
  logic [3:0]    r_mem_op [DEPTH];
  logic [3:0]    r_mem_a  [DEPTH];
  logic [3:0]    r_mem_b  [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [3:0]    r_alu_a;
  logic [3:0]    r_alu_b;
  logic [3:0]    r_alu_op;
  logic          r_res_valid;
  logic [3:0]    r_res_x;
  logic [3:0]    r_res_y;
  logic [3:0]    r_res_op;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [3:0]    w_san_x;
  logic [3:0]    w_san_y;

  assign w_empty   = (r_count == '0);
  assign cmd_ready = (r_count != L_FULL);
  assign w_push    = cmd_valid & cmd_ready;
  // The FSM is the only consumer: it pops when idle, or when the held result is accepted.
  assign w_pop     = !w_empty & ((r_state == S_IDLE) | ((r_state == S_RESULT) & res_ready));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_op[r_wptr] <= cmd_opcode;
      r_mem_a[r_wptr]  <= cmd_a;
      r_mem_b[r_wptr]  <= cmd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The ALU leaves bits it does not compute undefined, so only meaningful bits pass through.
  always_comb begin
    w_san_x = alu_x;
    w_san_y = 4'h0;
    case (r_alu_op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110,
      4'b0111, 4'b1000, 4'b1001:          w_san_x = {3'b000, alu_x[0]};
      4'b1010:                            w_san_y = {3'b000, alu_y[0]};
      4'b1100, 4'b1101, 4'b1110:          w_san_y = alu_y;
      default:                            w_san_y = 4'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_res_valid <= 1'b0;
      r_res_x     <= '0;
      r_res_y     <= '0;
      r_res_op    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_alu_a  <= r_mem_a[r_rptr];
            r_alu_b  <= r_mem_b[r_rptr];
            r_alu_op <= r_mem_op[r_rptr];
            r_state  <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_res_x     <= w_san_x;
          r_res_y     <= w_san_y;
          r_res_op    <= r_alu_op;
          r_res_valid <= 1'b1;
          r_state     <= S_RESULT;
        end
        S_RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (w_pop) begin
              r_alu_a  <= r_mem_a[r_rptr];
              r_alu_b  <= r_mem_b[r_rptr];
              r_alu_op <= r_mem_op[r_rptr];
              r_state  <= S_DRIVE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [STAT_W-1:0] r_op_count;

  always_ff @(posedge clk) begin
    if (rst)                          r_op_count <= '0;
    else if (r_res_valid & res_ready) r_op_count <= r_op_count + 1'b1;
  end

  assign op_count = r_op_count;
`endif

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_alu_op;
  assign res_valid  = r_res_valid;
  assign res_x      = r_res_x;
  assign res_y      = r_res_y;
  assign res_opcode = r_res_op;
  assign busy       = !w_empty | (r_state != S_IDLE);

endmodule
